// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame length and the
// round-robin pick helper used by TX (and later RX) sharing logic.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } arb_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int MAX_REQ         = 8;

    // First set bit of valid at or above ptr, wrapping within num entries.
    // Returns one-hot, or zero when nothing is valid.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int ptr,
                                                   input int num);
        logic [MAX_REQ-1:0] pick;
        int idx;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (ptr + k) % num;
            if (k < num && pick == '0 && valid[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester side and uart_tx side of the shared transmitter.
// master = arbiter view, slave = requesters plus uart_tx view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_ready;

    modport master (
        input  req_valid, req_data, req_lock, tx_ready,
        output req_ack, grant, tx_data, tx_send
    );

    modport slave (
        output req_valid, req_data, req_lock, tx_ready,
        input  req_ack, grant, tx_data, tx_send
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick with a registered rotation pointer.
// The pointer moves to the slot after the winner only when the pick is taken.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [IDX_W-1:0]   ptr_q;
    logic [MAX_REQ-1:0] valid_w;
    logic [MAX_REQ-1:0] pick_w;

    // Search from the pointer upward with wrap; also encode the winner index.
    always_comb begin
        valid_w              = '0;
        valid_w[NUM_REQ-1:0] = valid;
        pick_w               = rr_pick(valid_w, int'(ptr_q), NUM_REQ);
        pick                 = pick_w[NUM_REQ-1:0];
        pick_idx             = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick_w[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Pointer advances past the winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters with round-robin
// arbitration and an optional per-owner lock for multi-byte messages.
//
// state  | meaning
// S_IDLE | waiting for tx_ready=1 and an eligible requester
// S_SEND | tx_send held high until uart_tx drops tx_ready (or timeout)
// S_WAIT | tx_send low, waiting for uart_tx to finish the frame
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int SEND_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.master  bus,
    output logic               busy,
    output logic               tx_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SEND_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(SEND_TIMEOUT - 1);

    arb_state_t         state_q, state_nx;
    logic               tx_send_q, tx_send_nx;
    logic [7:0]         tx_data_q, tx_data_nx;
    logic [NUM_REQ-1:0] ack_q, ack_nx;
    logic [NUM_REQ-1:0] grant_q, grant_nx;
    logic               lock_q, lock_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               err_q, err_nx;
    logic               busy_q;

    logic               owner_lock;
    logic               hold_lock;
    logic [NUM_REQ-1:0] eligible;
    logic               take;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         sel_data;

    // The lock survives only while the current owner keeps req_lock high;
    // while it holds, a stalled owner blocks everyone else on purpose.
    assign owner_lock = |(bus.req_lock & grant_q);
    assign hold_lock  = lock_q && owner_lock;
    assign eligible   = hold_lock ? (bus.req_valid & grant_q) : bus.req_valid;
    assign take       = (state_q == S_IDLE) && bus.tx_ready && (|eligible);
    assign sel_data   = bus.req_data[int'(pick_idx)*8 +: 8];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid    (eligible),
        .advance  (take),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx   = state_q;
        tx_send_nx = tx_send_q;
        tx_data_nx = tx_data_q;
        ack_nx     = '0;
        grant_nx   = grant_q;
        lock_nx    = lock_q;
        cnt_nx     = cnt_q;
        err_nx     = err_q;
        case (state_q)
            S_IDLE: begin
                if (lock_q && !owner_lock) begin
                    lock_nx = 1'b0;
                end
                if (take) begin
                    state_nx   = S_SEND;
                    tx_send_nx = 1'b1;
                    tx_data_nx = sel_data;
                    ack_nx     = pick;
                    grant_nx   = pick;
                    lock_nx    = bus.req_lock[pick_idx];
                    cnt_nx     = '0;
                end
            end
            S_SEND: begin
                if (!bus.tx_ready) begin
                    state_nx   = S_WAIT;
                    tx_send_nx = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    // Byte already acked; it is dropped and the error latched.
                    state_nx   = S_IDLE;
                    tx_send_nx = 1'b0;
                    err_nx     = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                tx_send_nx = 1'b0;
                if (bus.tx_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx   = S_IDLE;
                tx_send_nx = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset abandons any in-flight byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_send_q <= 1'b0;
            tx_data_q <= 8'h00;
            ack_q     <= '0;
            grant_q   <= '0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tx_send_q <= tx_send_nx;
            tx_data_q <= tx_data_nx;
            ack_q     <= ack_nx;
            grant_q   <= grant_nx;
            lock_q    <= lock_nx;
            cnt_q     <= cnt_nx;
            err_q     <= err_nx;
            busy_q    <= (state_nx != S_IDLE);
        end
    end

    assign bus.tx_send = tx_send_q;
    assign bus.tx_data = tx_data_q;
    assign bus.req_ack = ack_q;
    assign bus.grant   = grant_q;
    assign busy        = busy_q;
    assign tx_err      = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte requesters, e.g. the CPU console port and the debug monitor.
- Arbitration is round-robin with an optional per-requester lock, so one requester can keep the line for a multi-byte message.
- The block drives uart_tx's level-held tx_send / tx_ready handshake and returns a one-cycle acknowledge to the requester whose byte was issued.
- It sits between the requesters and uart_tx in the top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SEND_TIMEOUT, 16, cycles to wait for tx_ready to fall after tx_send rises before flagging an error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- req_valid  in  NUM_REQ  requester i has a byte pending; held until req_ack[i].
- req_data  in  8*NUM_REQ  byte of requester i is req_data[8*i+7:8*i].
- req_lock  in  NUM_REQ  requester i asks to keep the grant after its current byte.
- req_ack  out  NUM_REQ  one-cycle pulse when requester i's byte is captured.
- grant  out  NUM_REQ  one-hot current/last owner; 0 after reset.
- busy  out  1  high whenever the FSM is not in S_IDLE.
- tx_err  out  1  sticky flag: SEND_TIMEOUT expired in S_SEND; cleared only by reset.
- tx_data  out  8  byte to uart_tx.
- tx_send  out  1  send request to uart_tx.
- tx_ready  in  1  uart_tx ready; low from the cycle after tx_send is sampled until uart_tx returns to idle.

Behaviour:
- Reset values:
  - State S_IDLE.
  - tx_send=0, tx_data=8'h00, req_ack=0, grant=0, busy=0, tx_err=0.
  - Round-robin pointer = index 0 (highest priority), lock released, timeout counter=0.
- All outputs are registered.

S_IDLE:
- Evaluate only when tx_ready=1.
- If the lock is held, the owner is the only eligible requester.
- Otherwise select the first i with req_valid[i] set, searching from the pointer upward with wrap.
- On a selection in cycle t, at t+1:
  - tx_data = selected byte, tx_send=1, req_ack[i]=1 for exactly one cycle.
  - grant = one-hot(i), lock = req_lock[i] sampled at t.
  - State goes to S_SEND.
- Pointer becomes (i+1) mod NUM_REQ.

S_SEND:
- Hold tx_send=1 and tx_data stable.
- When tx_ready=0 is sampled, drop tx_send next cycle and go to S_WAIT.
- Timeout counter increments each cycle in S_SEND. When it reaches SEND_TIMEOUT-1:
  - Set tx_err, drop tx_send, return to S_IDLE.
  - The ack has already been given; the byte is lost.

S_WAIT:
- tx_send=0. Dropping tx_send early is legal: uart_tx finishes all 10 bits, then returns to idle because tx_send is low.
- When tx_ready=1 is sampled, go to S_IDLE.
- Minimum spacing between bytes is one full frame plus 2 cycles.

Lock:
- Released in S_IDLE when the owner's req_lock=0.
- While locked, the owner with req_valid=0 stalls the line; other requesters wait. This is intentional and documented.

Boundary conditions:
- A requester dropping req_valid before its ack is allowed; its byte is simply not selected.
- req_valid changes during S_SEND/S_WAIT are ignored until S_IDLE.
- All requesters valid at once: strict rotation 0,1,..,NUM_REQ-1, no starvation.
- NUM_REQ=1: degenerates to a pass-through with handshake.
- reset_n low in any state: outputs return to reset values next cycle, any in-flight byte is abandoned, lock is cleared.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings S_IDLE/S_SEND/S_WAIT (2 bits);
  - UART_FRAME_BITS=10;
  - the function rr_pick(valid, ptr) returning a one-hot grant.
- One natural sub-module: rr_arbiter (combinational round-robin pick plus registered pointer), reused later for RX-side sharing.
- The top-level test instantiates uart_tx_arbiter together with uart_tx.

Test Plan:
- Single byte: req_valid[0]=1, data 8'h41, tx_ready idle → req_ack[0] pulses once, tx_send high until tx_ready falls, line shows 0x41 framed; busy clears after tx_ready returns.
- Contention: both valid, data 8'h31/8'h32, held across 4 bytes each → serial order 31,32,31,32,... with grant alternating.
- Lock: req_lock[1]=1 while sending "OK\r\n", req0 valid throughout → all 4 bytes of req1 go contiguous; req0's byte goes after lock drops.
- Timeout: tx_ready forced 1 after tx_send → tx_err=1 exactly SEND_TIMEOUT cycles after tx_send rises, FSM back to S_IDLE, next request still served.
- Reset mid-frame: reset_n low for 1 cycle during bit 4 → tx_send=0, grant=0, busy=0 next cycle; the following request completes normally.
- Rotation after idle: req1 served, then only req0 and req1 valid together → req0 served first (pointer wrapped to 0).
